// File: rtl/onehot_scan_decoder_if.sv
// Purpose: control/select bundle between display control logic and onehot_scan_decoder.
// Latency: none (wiring only); the decoder registers every output.
// Backpressure: none; the decoder accepts en_i/mode_i/in_i on every clk edge.
interface onehot_scan_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en_i;    // global enable; low blanks outputs and freezes the sequencer
  logic             mode_i;  // 0 = direct decode of in_i, 1 = auto-scan
  logic [SEL_W-1:0] in_i;    // channel select for direct mode
  logic [OUT_W-1:0] out_o;   // registered one-hot select
  logic [SEL_W-1:0] idx_o;   // registered current channel index
  logic             wrap_o;  // one-cycle pulse when the scan index wraps LAST -> 0

  // Control side: drives enable/mode/select and observes the select lines.
  modport master (
    output en_i,
    output mode_i,
    output in_i,
    input  out_o,
    input  idx_o,
    input  wrap_o
  );

  // Decoder side.
  modport slave (
    input  en_i,
    input  mode_i,
    input  in_i,
    output out_o,
    output idx_o,
    output wrap_o
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Purpose: registered binary-to-one-hot decoder with prescaled auto-scan (channels 0..LAST).
// Latency: 1 clk from en_i/mode_i/in_i to out_o/idx_o/wrap_o; scan step every DIV enabled cycles.
// Backpressure: none; en_i=0 blanks out_o and freezes idx and the prescaler in place.
// Build option: define ONEHOT_DEC_BLANK_EN to blank out_o for one cycle on every scan tick
// (anti-ghosting); requires DIV >= 2. Without it each channel is lit for the full step.
module onehot_scan_decoder #(
  parameter int SEL_W = 3,
  parameter int LAST  = 2 ** SEL_W - 1,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_scan_decoder_if.slave bus
);

  localparam int OUT_W = 2 ** SEL_W;
  // One prescaler bit minimum so DIV=1 still has a legal (always-zero) counter.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);

  logic [OUT_W-1:0] out_q,  out_d;
  logic [SEL_W-1:0] idx_q,  idx_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             tick;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Next-state: disable beats direct decode beats scan; wrap is decided against LAST,
  // never against index overflow, so a parked idx above LAST returns to 0 silently.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    out_d  = '0;
    wrap_d = 1'b0;
    tick   = 1'b0;

    if (!bus.en_i) begin
      // Outputs dark, sequencer frozen so a re-enable resumes the partial step.
      cnt_d = cnt_q;
      idx_d = idx_q;
    end else if (!bus.mode_i) begin
      // Direct decode; any in_i is decoded, LAST only bounds the scan.
      idx_d = bus.in_i;
      cnt_d = '0;
      out_d = onehot(bus.in_i);
    end else begin
      if (cnt_q == CNT_MAX) begin
        tick   = 1'b1;
        cnt_d  = '0;
        idx_d  = (idx_q >= LAST_IDX) ? '0 : idx_q + SEL_W'(1);
        wrap_d = (idx_q == LAST_IDX);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      out_d = onehot(idx_d);
`ifdef ONEHOT_DEC_BLANK_EN
      // Dark gap between channels so the previous digit cannot ghost into the next.
      if (tick) begin
        out_d = '0;
      end
`endif
    end
  end

  // State and output registers; reset parks the sweep at channel 0 with outputs dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out_o  = out_q;
  assign bus.idx_o  = idx_q;
  assign bus.wrap_o = wrap_q;

endmodule
